// File: rtl/rs_pkg.sv
// Shared constants and helpers for the reservation-station slice.
package rs_pkg;

  localparam int DEPTH_DEF    = 4;
  localparam int DATA_W_DEF   = 32;
  localparam int TAG_W_DEF    = 5;
  localparam int OP_W_DEF     = 5;
  localparam int TAG_BASE_DEF = 1;

  // Tag 0 means "operand value is present"; it is never a real producer.
  localparam int TAG_NONE = 0;

  function automatic int clog2_safe(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rs_age_select.sv
// Age matrix over the station entries plus an oldest-requester one-hot picker.
module rs_age_select #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DEPTH-1:0] alloc_vec,
  input  logic [DEPTH-1:0] free_vec,
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant
);

  // older_q[i][j] = 1 when entry i was allocated before entry j.
  logic [DEPTH-1:0] older_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (alloc_vec[i])
            older_q[i][j] <= 1'b0;
          else if (alloc_vec[j])
            older_q[i][j] <= 1'b1;
          else if (free_vec[i] || free_vec[j])
            older_q[i][j] <= 1'b0;
        end
      end
    end
  end

  // A requester wins when no other requester is older than it.
  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = req[i];
      for (int j = 0; j < DEPTH; j++)
        if (j != i && req[j] && older_q[j][i]) grant[i] = 1'b0;
    end
  end

endmodule

// File: rtl/rs_station_param.sv
// Tomasulo reservation station: captures CDB results into waiting entries and
// dispatches the oldest ready entry to one functional unit.
module rs_station_param
  import rs_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int TAG_W    = TAG_W_DEF,
  parameter int OP_W     = OP_W_DEF,
  parameter int TAG_BASE = TAG_BASE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_W-1:0]       in_op,
  input  logic [OP_W-1:0]       in_func,
  input  logic [DATA_W-1:0]     in_data1,
  input  logic [TAG_W-1:0]      in_tag1,
  input  logic [DATA_W-1:0]     in_data2,
  input  logic [TAG_W-1:0]      in_tag2,
  input  logic                  cdb_valid,
  input  logic [TAG_W-1:0]      cdb_tag,
  input  logic [DATA_W-1:0]     cdb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OP_W-1:0]       out_op,
  output logic [OP_W-1:0]       out_func,
  output logic [DATA_W-1:0]     out_data1,
  output logic [DATA_W-1:0]     out_data2,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int IDX_W = clog2_safe(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]  busy_q;
  logic [OP_W-1:0]   op_q   [DEPTH];
  logic [OP_W-1:0]   func_q [DEPTH];
  logic [DATA_W-1:0] vj_q   [DEPTH];
  logic [DATA_W-1:0] vk_q   [DEPTH];
  logic [TAG_W-1:0]  qj_q   [DEPTH];
  logic [TAG_W-1:0]  qk_q   [DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic              full_q;

  logic [DEPTH-1:0]  rdy;
  logic [DEPTH-1:0]  grant;
  logic [DEPTH-1:0]  alloc_vec;
  logic [DEPTH-1:0]  disp_vec;
  logic [IDX_W-1:0]  alloc_idx;
  logic              alloc_en;
  logic              disp_en;
  logic [CNT_W-1:0]  count_nxt;

  function automatic logic cdb_hit(input logic [TAG_W-1:0] q);
    return cdb_valid && (cdb_tag != TAG_W'(TAG_NONE)) && (q == cdb_tag);
  endfunction

  // Both ports use valid/ready: a transfer happens on a cycle where valid && ready
  // at the rising edge; ready/valid never depend on a same-cycle transfer elsewhere.
  assign in_ready = !rst && !flush && !full_q;
  assign alloc_en = in_valid && in_ready;

  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!busy_q[i]) alloc_idx = IDX_W'(i);
  end

  always_comb begin
    alloc_vec = '0;
    if (alloc_en) alloc_vec[alloc_idx] = 1'b1;
  end

  always_comb begin
    rdy = '0;
    for (int i = 0; i < DEPTH; i++)
      rdy[i] = busy_q[i] && (qj_q[i] == TAG_W'(TAG_NONE)) && (qk_q[i] == TAG_W'(TAG_NONE));
  end

  rs_age_select #(.DEPTH(DEPTH)) u_age (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .alloc_vec (alloc_vec),
    .free_vec  (disp_vec),
    .req       (rdy),
    .grant     (grant)
  );

  assign out_valid = !rst && !flush && (|rdy);
  assign disp_en   = out_valid && out_ready;
  assign disp_vec  = grant & {DEPTH{disp_en}};

  always_comb begin
    out_op    = '0;
    out_func  = '0;
    out_data1 = '0;
    out_data2 = '0;
    out_tag   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (out_valid && grant[i]) begin
        out_op    = op_q[i];
        out_func  = func_q[i];
        out_data1 = vj_q[i];
        out_data2 = vk_q[i];
        out_tag   = TAG_W'(TAG_BASE + i);
      end
    end
  end

  assign count_nxt = count_q + CNT_W'(alloc_en) - CNT_W'(disp_en);
  assign count     = rst ? '0 : count_q;
  assign full      = !rst && full_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i] && cdb_hit(qj_q[i])) begin
          vj_q[i] <= cdb_data;
          qj_q[i] <= '0;
        end
        if (busy_q[i] && cdb_hit(qk_q[i])) begin
          vk_q[i] <= cdb_data;
          qk_q[i] <= '0;
        end
        if (disp_vec[i]) busy_q[i] <= 1'b0;
        // Allocation also snoops the CDB so a same-cycle broadcast is not lost.
        if (alloc_vec[i]) begin
          busy_q[i] <= 1'b1;
          op_q[i]   <= in_op;
          func_q[i] <= in_func;
          if (cdb_hit(in_tag1)) begin
            vj_q[i] <= cdb_data;
            qj_q[i] <= '0;
          end else begin
            vj_q[i] <= in_data1;
            qj_q[i] <= in_tag1;
          end
          if (cdb_hit(in_tag2)) begin
            vk_q[i] <= cdb_data;
            qk_q[i] <= '0;
          end else begin
            vk_q[i] <= in_data2;
            qk_q[i] <= in_tag2;
          end
        end
      end
      count_q <= count_nxt;
      full_q  <= (count_nxt == CNT_W'(DEPTH));
    end
  end

endmodule
